// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl
// Multicycle data-memory controller with its own MAR/MDR. A request is
// sampled in IDLE or DONE, optionally delayed by WAIT_CYCLES wait states,
// then the byte-addressed array is read or written on the ACCESS exit edge.
// Byte/halfword/word accesses, sign or zero extension, selectable
// endianness and alignment checking.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   req      - start an access (sampled in IDLE/DONE only)
//   rw       - 1 = load, 0 = store
//   size     - 00 byte, 01 halfword, 10 word, 11 illegal
//   unsign   - loads: 1 = zero-extend, 0 = sign-extend
//   addr     - byte address, latched into MAR
//   wdata    - store data (low byte/half/word used per size)
//   rdata    - MDR, extended load result
//   moc      - memory operation complete, one-cycle pulse
//   busy     - access in progress (WAIT/ACCESS)
//   addr_err - misaligned or illegal access, one-cycle pulse
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for req
// WAIT   | counting down wait states
// ACCESS | array read/write happens on the exit edge
// DONE   | moc pulse; req sampled again for back-to-back use
// ERR    | addr_err pulse; req ignored, returns to IDLE
module mdr_mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              unsign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              moc,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   mar_q,    mar_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic                rw_q,     rw_d;
    logic [1:0]          size_q,   size_d;
    logic                unsign_q, unsign_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [31:0]         rdata_q,  rdata_d;
    logic                moc_q,    moc_d;
    logic                busy_q,   busy_d;
    logic                err_q,    err_d;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rb  [4];
    logic [7:0]  wb  [4];
    logic [3:0]  we_lane;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic        bad_req;

    // Accesses are aligned by the time they reach ACCESS, so OR-ing the
    // lane index into MAR gives each byte address without a carry chain.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rb[k] = mem[mar_q | ADDR_W'(k)];
        end
    end

    always_comb begin
        half_val = BIG_ENDIAN ? {rb[0], rb[1]} : {rb[1], rb[0]};
        load_val = '0;
        case (size_q)
            2'b00:   load_val = unsign_q ? {24'd0, rb[0]} : {{24{rb[0][7]}}, rb[0]};
            2'b01:   load_val = unsign_q ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
            2'b10:   load_val = BIG_ENDIAN ? {rb[0], rb[1], rb[2], rb[3]}
                                           : {rb[3], rb[2], rb[1], rb[0]};
            default: load_val = '0;
        endcase
    end

    // Byte-lane write data and enables, lane k maps to address MAR+k.
    always_comb begin
        we_lane = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wb[k] = 8'd0;
        end
        if (state_q == S_ACCESS && !rw_q) begin
            case (size_q)
                2'b00: begin
                    we_lane = 4'b0001;
                    wb[0]   = wdata_q[7:0];
                end
                2'b01: begin
                    we_lane = 4'b0011;
                    wb[0]   = BIG_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
                    wb[1]   = BIG_ENDIAN ? wdata_q[7:0]  : wdata_q[15:8];
                end
                2'b10: begin
                    we_lane = 4'b1111;
                    for (int k = 0; k < 4; k++) begin
                        wb[k] = BIG_ENDIAN ? wdata_q[31-8*k -: 8] : wdata_q[8*k+7 -: 8];
                    end
                end
                default: we_lane = 4'b0000;
            endcase
        end
    end

    // The array is intentionally not reset. An asserted reset forces
    // state_q out of ACCESS immediately, which blocks any pending write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_lane[k]) begin
                mem[mar_q | ADDR_W'(k)] <= wb[k];
            end
        end
    end

    assign bad_req = (size == 2'b11)
                   || (size == 2'b01 && addr[0])
                   || (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        size_d   = size_q;
        unsign_d = unsign_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (req) begin
                    mar_d    = addr;
                    wdata_d  = wdata;
                    rw_d     = rw;
                    size_d   = size;
                    unsign_d = unsign;
                    if (bad_req) begin
                        state_d = S_ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (rw_q) begin
                    rdata_d = load_val;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered copies of the next-state decode.
        moc_d  = (state_d == S_DONE);
        busy_d = (state_d == S_WAIT) || (state_d == S_ACCESS);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mar_q    <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            size_q   <= 2'b00;
            unsign_q <= 1'b0;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            moc_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            unsign_q <= unsign_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            moc_q    <= moc_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign rdata    = rdata_q;
    assign moc      = moc_q;
    assign busy     = busy_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed testbench for mdr_mem_ctrl. Three instances with different
// parameters (index 0: 2 wait states big-endian, 1: no wait states
// big-endian, 2: 2 wait states little-endian), each with its own inputs,
// sharing clock and reset.
module tb_mdr_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req    [3];
    logic        rw     [3];
    logic [1:0]  size   [3];
    logic        unsign [3];
    logic [8:0]  addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];
    logic        moc    [3];
    logic        busy   [3];
    logic        aerr   [3];

    int tests = 0;
    int fails = 0;

    mdr_mem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2), .BIG_ENDIAN(1'b1)) u_a (
        .clk(clk), .reset(reset), .req(req[0]), .rw(rw[0]), .size(size[0]),
        .unsign(unsign[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .moc(moc[0]), .busy(busy[0]), .addr_err(aerr[0]));

    mdr_mem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(0), .BIG_ENDIAN(1'b1)) u_b (
        .clk(clk), .reset(reset), .req(req[1]), .rw(rw[1]), .size(size[1]),
        .unsign(unsign[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .moc(moc[1]), .busy(busy[1]), .addr_err(aerr[1]));

    mdr_mem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2), .BIG_ENDIAN(1'b0)) u_c (
        .clk(clk), .reset(reset), .req(req[2]), .rw(rw[2]), .size(size[2]),
        .unsign(unsign[2]), .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]),
        .moc(moc[2]), .busy(busy[2]), .addr_err(aerr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request pulse; lat = edges after the sampling edge until moc or
    // addr_err is seen (-1 on timeout), bsy = cycles with busy high before it.
    // Inputs are scrambled right after the sampling edge to prove latching.
    task automatic do_acc(input int d, input logic r, input logic [1:0] sz,
                          input logic us, input logic [8:0] a, input logic [31:0] wd,
                          output int lat, output int bsy, output logic err);
        @(negedge clk);
        req[d] = 1'b1; rw[d] = r; size[d] = sz; unsign[d] = us; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        req[d] = 1'b0; rw[d] = ~r; size[d] = ~sz; unsign[d] = ~us; addr[d] = ~a; wdata[d] = ~wd;
        lat = -1; bsy = 0; err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy[d]) bsy++;
            if (moc[d] || aerr[d]) begin
                lat = k;
                err = aerr[d];
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int   lat, bsy, mcnt;
        logic err;
        logic [4:0] mpat;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; rw[d] = 1'b0; size[d] = 2'b00; unsign[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_moc",   {31'd0, moc[0]}, 32'd0);
        check("rst_busy",  {31'd0, busy[0]}, 32'd0);
        check("rst_err",   {31'd0, aerr[0]}, 32'd0);
        reset = 1'b0;

        // 1: word store/load, 2 wait states
        do_acc(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, lat, bsy, err);
        check("t1_st_lat",  lat, 3);
        check("t1_st_busy", bsy, 3);
        check("t1_st_rdata_held", rdata[0], 32'h0);
        @(negedge clk);
        check("t1_moc_pulse", {31'd0, moc[0]}, 32'd0);
        do_acc(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, lat, bsy, err);
        check("t1_ld_lat",  lat, 3);
        check("t1_ld_busy", bsy, 3);
        check("t1_ld_word", rdata[0], 32'hDEADBEEF);

        // 2: byte load, sign and zero extension
        do_acc(0, 1'b1, 2'b00, 1'b0, 9'h011, 32'h0, lat, bsy, err);
        check("t2_lb_sext", rdata[0], 32'hFFFFFFAD);
        do_acc(0, 1'b1, 2'b00, 1'b1, 9'h011, 32'h0, lat, bsy, err);
        check("t2_lb_zext", rdata[0], 32'h000000AD);

        // 3: byte store merges into the word
        do_acc(0, 1'b0, 2'b00, 1'b0, 9'h012, 32'hFFFFFF5A, lat, bsy, err);
        do_acc(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, lat, bsy, err);
        check("t3_lw_merge", rdata[0], 32'hDEAD5AEF);
        do_acc(0, 1'b1, 2'b01, 1'b0, 9'h012, 32'h0, lat, bsy, err);
        check("t3_lh", rdata[0], 32'h00005AEF);

        // 4: misaligned word store, illegal size
        do_acc(0, 1'b0, 2'b10, 1'b0, 9'h013, 32'h01020304, lat, bsy, err);
        check("t4_mis_err", {31'd0, err}, 32'd1);
        check("t4_mis_lat", lat, 0);
        check("t4_mis_busy", bsy, 0);
        check("t4_mis_rdata", rdata[0], 32'h00005AEF);
        @(negedge clk);
        check("t4_err_pulse", {31'd0, aerr[0]}, 32'd0);
        check("t4_no_moc",    {31'd0, moc[0]}, 32'd0);
        do_acc(0, 1'b1, 2'b11, 1'b0, 9'h010, 32'h0, lat, bsy, err);
        check("t4_ill_err", {31'd0, err}, 32'd1);
        check("t4_ill_rdata", rdata[0], 32'h00005AEF);
        do_acc(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, lat, bsy, err);
        check("t4_mem_kept", rdata[0], 32'hDEAD5AEF);
        check("t4_after_lat", lat, 3);

        // halfword store, signed halfword and unsigned byte loads
        do_acc(0, 1'b0, 2'b01, 1'b0, 9'h018, 32'h12348001, lat, bsy, err);
        do_acc(0, 1'b1, 2'b01, 1'b0, 9'h018, 32'h0, lat, bsy, err);
        check("hw_lh_sext", rdata[0], 32'hFFFF8001);
        do_acc(0, 1'b1, 2'b00, 1'b1, 9'h019, 32'h0, lat, bsy, err);
        check("hw_lb_lane", rdata[0], 32'h00000001);

        // 5: no wait states, back-to-back reads with req held
        do_acc(1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h12345678, lat, bsy, err);
        check("t5_st_lat", lat, 1);
        do_acc(1, 1'b0, 2'b10, 1'b0, 9'h014, 32'hCAFEF00D, lat, bsy, err);
        @(negedge clk);
        req[1] = 1'b1; rw[1] = 1'b1; size[1] = 2'b10; unsign[1] = 1'b0; addr[1] = 9'h010;
        @(negedge clk);
        mpat[0] = moc[1];
        addr[1] = 9'h014;
        @(negedge clk);
        mpat[1] = moc[1];
        check("t5_rd1", rdata[1], 32'h12345678);
        @(negedge clk);
        mpat[2] = moc[1];
        req[1] = 1'b0;
        @(negedge clk);
        mpat[3] = moc[1];
        check("t5_rd2", rdata[1], 32'hCAFEF00D);
        @(negedge clk);
        mpat[4] = moc[1];
        check("t5_moc_pattern", {27'd0, mpat}, 32'h0000000A);

        // 5b: reset during WAIT aborts the store
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b0; size[0] = 2'b10; addr[0] = 9'h010; wdata[0] = 32'h11223344;
        @(negedge clk);
        req[0] = 1'b0;
        check("t5_in_wait", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (moc[0]) mcnt++;
            @(negedge clk);
        end
        check("t5_rst_no_moc", mcnt, 0);
        do_acc(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, lat, bsy, err);
        check("t5_rst_mem_kept", rdata[0], 32'hDEAD5AEF);

        // 6: little-endian
        do_acc(2, 1'b0, 2'b10, 1'b0, 9'h020, 32'h11223344, lat, bsy, err);
        check("t6_st_lat", lat, 3);
        do_acc(2, 1'b1, 2'b00, 1'b0, 9'h020, 32'h0, lat, bsy, err);
        check("t6_lb", rdata[2], 32'h00000044);
        do_acc(2, 1'b1, 2'b01, 1'b0, 9'h022, 32'h0, lat, bsy, err);
        check("t6_lh", rdata[2], 32'h00001122);
        do_acc(2, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0, lat, bsy, err);
        check("t6_lw", rdata[2], 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
Multicycle data-memory controller for the MIPS datapath. It sits between the control unit and a byte-addressed RAM, and holds its own MAR and MDR registers. Every access is a req/moc handshake with a programmable number of wait states. It supports byte, halfword and word accesses, sign or zero extension, selectable endianness, and alignment checking.

Parameters:
ADDR_W, 9, byte-address width; memory depth is 2**ADDR_W bytes.
WAIT_CYCLES, 2, wait states inserted before the array access (0..15).
BIG_ENDIAN, 1, 1 = MIPS big-endian (byte at addr is data[31:24]); 0 = little-endian.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  1  start access; sampled only in IDLE or DONE.
rw  in  1  1 = read (load), 0 = write (store).
size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
unsign  in  1  loads: 1 = zero-extend, 0 = sign-extend.
addr  in  ADDR_W  byte address, latched into MAR.
wdata  in  32  store data; low byte/half/word used per size.
rdata  out  32  MDR; extended load result.
moc  out  1  memory operation complete; one-cycle pulse.
busy  out  1  access in progress.
addr_err  out  1  misaligned or illegal access; one-cycle pulse.

Behaviour:
- One clock domain: clk. Asynchronous, active-high reset: reset.
- Reset values:
  - state = IDLE; rdata = 0; moc = 0; busy = 0; addr_err = 0.
  - MAR, the latched controls and the wait counter are cleared.
  - Memory array is NOT cleared.
- FSM states: IDLE, WAIT, ACCESS, DONE, ERR.
- IDLE or DONE, with req = 1 at edge E0:
  - Latch MAR = addr, wdata, rw, size and unsign.
  - Check alignment:
    - Misaligned when size = 01 and addr[0] = 1.
    - Misaligned when size = 10 and addr[1:0] != 0.
    - size = 11 is always illegal.
  - Misaligned or illegal: go to ERR.
  - Otherwise, WAIT_CYCLES > 0: go to WAIT, counter = WAIT_CYCLES - 1.
  - Otherwise (WAIT_CYCLES = 0): go to ACCESS.
- IDLE or DONE with req = 0: go to (or stay in) IDLE.
- WAIT: decrement the counter each cycle; go to ACCESS on the edge where the counter is 0.
- ACCESS: on the exit edge, perform the array operation, then go to DONE.
  - Write: update only the addressed bytes; other bytes are unchanged.
  - Read: load rdata with the assembled value.
    - Byte and halfword results are sign- or zero-extended to 32 bits per unsign.
    - Byte order follows BIG_ENDIAN.
- DONE: moc = 1 for exactly this cycle. req is sampled as in IDLE, so back-to-back accesses are legal.
- ERR: addr_err = 1 for exactly one cycle. No memory change, rdata is held, moc stays 0. Next state is IDLE; req is ignored in ERR.
- Latency: moc is high in the cycle after edge E(WAIT_CYCLES+1), counted from the sampling edge E0.
- busy = 1 in WAIT and ACCESS; busy = 0 in IDLE, DONE and ERR.
- req is ignored while busy. Input changes after E0 have no effect on the current access.
- rdata changes only on a completed read; writes and errors leave it unchanged.
- Address wrap: MAR is ADDR_W bits, so there is no wrap within an aligned access.
- Reset mid-access:
  - Before the ACCESS exit edge, the access is aborted and memory is untouched.
  - After that edge, the write has already committed.
- The implementation must not use latches. All outputs are registered.

Test Plan:
1. WAIT_CYCLES=2, BIG_ENDIAN=1: store word 0xDEADBEEF at addr 0x010, then load word at 0x010. Required: moc high 3 cycles after each req edge, rdata = 0xDEADBEEF, busy high for exactly 3 cycles per access.
2. After test 1, load byte at 0x011. Required: unsign=0 gives rdata = 0xFFFFFFAD; unsign=1 gives rdata = 0x000000AD.
3. Store byte 0x5A at 0x012, then load word at 0x010. Required: rdata = 0xDEAD5AEF. Load half at 0x012 with unsign=0: rdata = 0x00005AEF.
4. Store word at 0x013, and separately an access with size=11. Required: addr_err pulses one cycle, moc stays 0, memory and rdata unchanged, state returns to IDLE.
5. WAIT_CYCLES=0, req held high for two back-to-back reads. Required: moc pulses one edge after each ACCESS, two pulses in 4 cycles. Asserting reset while in WAIT during a store of 0x11223344: moc never asserts, and the target word keeps its old value.
6. BIG_ENDIAN=0: store word 0x11223344 at 0x020, then load byte at 0x020. Required: rdata = 0x00000044.
